// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the gshare direction predictor.
package bp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // Helpers work on a wide container; callers cast down to their CTR_W.
  localparam int CTR_MAX_W = 8;
  typedef logic [CTR_MAX_W-1:0] ctr_t;

  function automatic ctr_t ctr_init(input int ctr_w);
    return ctr_t'((1 << (ctr_w - 1)) - 1);
  endfunction

  function automatic ctr_t sat_step(input ctr_t ctr, input logic up, input int ctr_w);
    ctr_t max_v;
    max_v = ctr_t'((1 << ctr_w) - 1);
    if (up) begin
      return (ctr == max_v) ? ctr : ctr + 1'b1;
    end
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Predict (IF) and train (EX) port bundle of the gshare predictor.
interface gshare_predictor_if #(
  parameter int IDX_W    = 8,
  parameter int HIST_LEN = 8
);
  logic                pred_valid;
  logic [31:0]         pred_pc;
  logic                pred_taken;
  logic [IDX_W-1:0]    pred_idx;
  logic [HIST_LEN-1:0] pred_ghr;
  logic                upd_valid;
  logic [IDX_W-1:0]    upd_idx;
  logic [HIST_LEN-1:0] upd_ghr;
  logic                upd_taken;
  logic                upd_mispredict;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
    input  pred_taken, pred_idx, pred_ghr
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
    output pred_taken, pred_idx, pred_ghr
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// Combinational CTR_W-bit saturating increment/decrement.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             up_i,
  output logic [CTR_W-1:0] ctr_o
);

  assign ctr_o = CTR_W'(sat_step(ctr_t'(ctr_i), up_i, CTR_W));

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC^GHR indexed counter table, speculative GHR with repair.
// Optional performance counters are built when GSHARE_PERF_CNT_EN is defined.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W    = 8,
  parameter int HIST_LEN = 8,
  parameter int CTR_W    = 2,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  gshare_predictor_if.slave bp,
  output logic [PERF_W-1:0] perf_preds,
  output logic [PERF_W-1:0] perf_correct
);

  localparam int              DEPTH    = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

  bp_state_e           state_q;
  logic [IDX_W-1:0]    init_ptr_q;
  logic                init_done_q;
  logic [HIST_LEN-1:0] ghr_q, ghr_d;
  logic [CTR_W-1:0]    table_q [DEPTH];

  logic [IDX_W-1:0]    idx;
  logic [CTR_W-1:0]    rd_ctr;
  logic [CTR_W-1:0]    upd_next;
  logic                run;
  logic                unused_pc;

  assign run       = (state_q == RUN);
  assign unused_pc = ^{bp.pred_pc[31:IDX_W+2], bp.pred_pc[1:0]};

  // Lookup: same-cycle read, so a colliding update is seen only next cycle.
  assign idx           = bp.pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign rd_ctr        = table_q[idx];
  assign bp.pred_idx   = idx;
  assign bp.pred_ghr   = ghr_q;
  assign bp.pred_taken = run & rd_ctr[CTR_W-1];
  assign init_done     = init_done_q;

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat (
    .ctr_i (table_q[bp.upd_idx]),
    .up_i  (bp.upd_taken),
    .ctr_o (upd_next)
  );

  // A mispredict repair wins: a same-cycle fetch is already on the wrong path.
  always_comb begin
    ghr_d = ghr_q;
    if (run) begin
      if (bp.upd_valid && bp.upd_mispredict) begin
        ghr_d = HIST_LEN'({bp.upd_ghr, bp.upd_taken});
      end else if (bp.pred_valid) begin
        ghr_d = HIST_LEN'({ghr_q, bp.pred_taken});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      init_done_q <= 1'b0;
      ghr_q       <= '0;
    end else begin
      ghr_q <= ghr_d;
      case (state_q)
        INIT: begin
          init_ptr_q <= init_ptr_q + 1'b1;
          if (init_ptr_q == IDX_W'(DEPTH - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      table_q[init_ptr_q] <= CTR_INIT;
    end else if (bp.upd_valid) begin
      table_q[bp.upd_idx] <= upd_next;
    end
  end

`ifdef GSHARE_PERF_CNT_EN
  logic [PERF_W-1:0] preds_q, correct_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preds_q   <= '0;
      correct_q <= '0;
    end else if (run && bp.upd_valid) begin
      preds_q <= preds_q + 1'b1;
      if (!bp.upd_mispredict) correct_q <= correct_q + 1'b1;
    end
  end

  assign perf_preds   = preds_q;
  assign perf_correct = correct_q;
`else
  assign perf_preds   = '0;
  assign perf_correct = '0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor against a behavioural table/history model.
module tb_gshare_predictor;

  localparam int IDX_W = 8, HIST_LEN = 8, CTR_W = 2, PERF_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              init_done;
  logic [PERF_W-1:0] perf_preds, perf_correct;

  always #5 clk = ~clk;

  gshare_predictor_if #(.IDX_W(IDX_W), .HIST_LEN(HIST_LEN)) bp ();

  gshare_predictor #(.IDX_W(IDX_W), .HIST_LEN(HIST_LEN), .CTR_W(CTR_W), .PERF_W(PERF_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_done    (init_done),
    .bp           (bp),
    .perf_preds   (perf_preds),
    .perf_correct (perf_correct)
  );

  int checks = 0;
  int passed = 0;

  int m_tbl [256];
  int m_ghr;
  int m_preds, m_correct;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp.pred_valid     = 1'b0;
    bp.upd_valid      = 1'b0;
    bp.upd_idx        = '0;
    bp.upd_ghr        = '0;
    bp.upd_taken      = 1'b0;
    bp.upd_mispredict = 1'b0;
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return ((pc >> 2) & 255) ^ m_ghr;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_tbl[i] = 1;
    m_ghr     = 0;
    m_preds   = 0;
    m_correct = 0;
  endtask

  // Apply the current inputs to the model as one clock edge in the live state.
  task automatic model_edge();
    int pt;
    int ui;
    pt = (m_tbl[m_idx(bp.pred_pc)] >= 2) ? 1 : 0;
    if (bp.upd_valid) begin
      ui = int'(bp.upd_idx);
      if (bp.upd_taken) m_tbl[ui] = (m_tbl[ui] < 3) ? m_tbl[ui] + 1 : 3;
      else              m_tbl[ui] = (m_tbl[ui] > 0) ? m_tbl[ui] - 1 : 0;
      m_preds = (m_preds + 1) % 65536;
      if (!bp.upd_mispredict) m_correct = (m_correct + 1) % 65536;
    end
    if (bp.upd_valid && bp.upd_mispredict)
      m_ghr = ((int'(bp.upd_ghr) * 2) + int'(bp.upd_taken)) % 256;
    else if (bp.pred_valid)
      m_ghr = ((m_ghr * 2) + pt) % 256;
  endtask

  task automatic sweep_from_release(input string tag);
    for (int c = 1; c <= 256; c++) begin
      bp.pred_valid     = 1'($urandom);
      bp.pred_pc        = $urandom;
      bp.upd_valid      = 1'($urandom);
      bp.upd_idx        = 8'($urandom);
      bp.upd_ghr        = 8'($urandom);
      bp.upd_taken      = 1'($urandom);
      bp.upd_mispredict = 1'($urandom);
      #1;
      checks++;
      if (bp.pred_taken !== 1'b0) $display("FAIL %s_init_pred_taken c=%0d: got %b want 0", tag, c, bp.pred_taken);
      else passed++;
      step();
      checks++;
      if (init_done !== (c == 256)) $display("FAIL %s_init_done c=%0d: got %b want %b", tag, c, init_done, (c == 256));
      else passed++;
    end
    idle();
    model_reset();
    #1;
    checks++;
    if (bp.pred_ghr !== 8'h00) $display("FAIL %s_ghr_after_init: got %h want 00", tag, bp.pred_ghr);
    else passed++;
  endtask

  task automatic test_reset();
    int bad;
    idle();
    bp.pred_pc = 32'h40;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (init_done !== 1'b0 || bp.pred_taken !== 1'b0 || bp.pred_ghr !== 8'h00)
      $display("FAIL reset_outputs: got init_done=%b taken=%b ghr=%h want 0 0 00", init_done, bp.pred_taken, bp.pred_ghr);
    else passed++;
    checks++;
    if (bp.pred_idx !== 8'h10) $display("FAIL reset_pred_idx: got %h want 10", bp.pred_idx);
    else passed++;
    checks++;
    if (perf_preds !== 16'd0 || perf_correct !== 16'd0)
      $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_preds, perf_correct);
    else passed++;
    rst_n = 1'b1;
    sweep_from_release("reset");
    bad = 0;
    for (int i = 0; i < 256; i++) if (dut.table_q[i] !== 2'b01) bad++;
    checks++;
    if (bad != 0) $display("FAIL table_init: got %0d entries != 01 want 0", bad);
    else passed++;
  endtask

  task automatic test_train_up();
    int want [3] = '{2, 3, 3};
    idle();
    bp.pred_pc = 32'h40;
    #1;
    checks++;
    if (bp.pred_idx !== 8'h10 || bp.pred_taken !== 1'b0)
      $display("FAIL lookup_0x40: got idx=%h taken=%b want 10 0", bp.pred_idx, bp.pred_taken);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      bp.upd_valid = 1'b1; bp.upd_idx = 8'h10; bp.upd_taken = 1'b1; bp.upd_mispredict = 1'b0;
      model_edge();
      step();
      idle();
      checks++;
      if (dut.table_q[16] !== 2'(want[k]) || m_tbl[16] != want[k])
        $display("FAIL train_up[%0d]: got %0d want %0d", k, dut.table_q[16], want[k]);
      else passed++;
    end
    checks++;
    if (bp.pred_taken !== 1'b1) $display("FAIL train_up_pred: got %b want 1", bp.pred_taken);
    else passed++;
  endtask

  task automatic test_train_down();
    int want [4] = '{2, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      bp.upd_valid = 1'b1; bp.upd_idx = 8'h10; bp.upd_taken = 1'b0; bp.upd_mispredict = 1'b0;
      model_edge();
      step();
      idle();
      checks++;
      if (dut.table_q[16] !== 2'(want[k]))
        $display("FAIL train_down[%0d]: got %0d want %0d", k, dut.table_q[16], want[k]);
      else passed++;
    end
    checks++;
    if (bp.pred_taken !== 1'b0) $display("FAIL train_down_pred: got %b want 0", bp.pred_taken);
    else passed++;
  endtask

  task automatic test_repair();
    bp.pred_pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      bp.pred_valid = 1'b1;
      #1;
      checks++;
      if (bp.pred_taken !== 1'b0) $display("FAIL spec_pred[%0d]: got %b want 0", k, bp.pred_taken);
      else passed++;
      model_edge();
      step();
    end
    idle();
    checks++;
    if (bp.pred_ghr !== 8'h00) $display("FAIL spec_ghr: got %h want 00", bp.pred_ghr);
    else passed++;
    bp.pred_valid = 1'b1;
    bp.upd_valid = 1'b1; bp.upd_mispredict = 1'b1; bp.upd_ghr = 8'h05;
    bp.upd_taken = 1'b1; bp.upd_idx = 8'h30;
    model_edge();
    step();
    idle();
    checks++;
    if (bp.pred_ghr !== 8'h0B || m_ghr != 8'h0B) $display("FAIL repair_ghr: got %h want 0b", bp.pred_ghr);
    else passed++;
  endtask

  task automatic test_rbw();
    idle();
    bp.pred_pc = 32'((8'h22 ^ m_ghr) << 2);
    bp.upd_valid = 1'b1; bp.upd_idx = 8'h22; bp.upd_taken = 1'b1; bp.upd_mispredict = 1'b0;
    #1;
    checks++;
    if (bp.pred_idx !== 8'h22 || bp.pred_taken !== 1'b0)
      $display("FAIL rbw_same_cycle: got idx=%h taken=%b want 22 0", bp.pred_idx, bp.pred_taken);
    else passed++;
    model_edge();
    step();
    idle();
    checks++;
    if (bp.pred_taken !== 1'b1) $display("FAIL rbw_next_cycle: got %b want 1", bp.pred_taken);
    else passed++;
  endtask

  task automatic test_random();
    int errs;
    logic [7:0] eidx;
    errs = 0;
    for (int n = 0; n < 600; n++) begin
      bp.pred_valid     = 1'($urandom_range(0, 3) != 0);
      bp.pred_pc        = $urandom;
      bp.upd_valid      = 1'($urandom);
      bp.upd_ghr        = 8'($urandom);
      bp.upd_taken      = 1'($urandom);
      bp.upd_mispredict = 1'($urandom_range(0, 3) == 0);
      eidx = 8'(m_idx(bp.pred_pc));
      bp.upd_idx = ($urandom_range(0, 3) == 0) ? eidx : 8'($urandom_range(0, 15));
      #1;
      if (bp.pred_idx !== eidx || bp.pred_ghr !== 8'(m_ghr) ||
          bp.pred_taken !== (m_tbl[eidx] >= 2)) begin
        if (errs < 5)
          $display("FAIL random[%0d]: got idx=%h ghr=%h taken=%b want %h %h %b", n,
                   bp.pred_idx, bp.pred_ghr, bp.pred_taken, eidx, 8'(m_ghr), (m_tbl[eidx] >= 2));
        errs++;
      end
      model_edge();
      step();
    end
    idle();
    checks++;
    if (errs != 0) $display("FAIL random_total: got %0d bad cycles want 0", errs);
    else passed++;
`ifdef GSHARE_PERF_CNT_EN
    checks++;
    if (perf_preds !== 16'(m_preds) || perf_correct !== 16'(m_correct))
      $display("FAIL random_perf: got %0d/%0d want %0d/%0d", perf_preds, perf_correct, m_preds, m_correct);
    else passed++;
`else
    checks++;
    if (perf_preds !== 16'd0 || perf_correct !== 16'd0)
      $display("FAIL perf_tied: got %0d/%0d want 0/0", perf_preds, perf_correct);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (100) step();
    checks++;
    if (dut.init_ptr_q !== 8'd100 || init_done !== 1'b0)
      $display("FAIL mid_ptr: got ptr=%0d done=%b want 100 0", dut.init_ptr_q, init_done);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut.init_ptr_q !== 8'd0 || init_done !== 1'b0 || bp.pred_ghr !== 8'h00)
      $display("FAIL mid_abort: got ptr=%0d done=%b ghr=%h want 0 0 00", dut.init_ptr_q, init_done, bp.pred_ghr);
    else passed++;
    step();
    rst_n = 1'b1;
    sweep_from_release("mid");
    for (int k = 0; k < 5; k++) begin
      bp.upd_valid = 1'b1; bp.upd_idx = 8'(k); bp.upd_ghr = 8'(k * 3);
      bp.upd_taken = 1'(k); bp.upd_mispredict = (k == 1 || k == 3);
      model_edge();
      step();
    end
    idle();
    checks++;
    if (bp.pred_ghr !== 8'(m_ghr)) $display("FAIL mid_ghr: got %h want %h", bp.pred_ghr, 8'(m_ghr));
    else passed++;
`ifdef GSHARE_PERF_CNT_EN
    checks++;
    if (perf_preds !== 16'd5 || perf_correct !== 16'd3)
      $display("FAIL perf_counts: got %0d/%0d want 5/3", perf_preds, perf_correct);
    else passed++;
`else
    checks++;
    if (perf_preds !== 16'd0 || perf_correct !== 16'd0)
      $display("FAIL perf_tied_after: got %0d/%0d want 0/0", perf_preds, perf_correct);
    else passed++;
`endif
  endtask

  initial begin
    bp.pred_pc = '0;
    idle();
    model_reset();
    test_reset();
    test_train_up();
    test_train_down();
    test_repair();
    test_rbw();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
